// File: rtl/frac_mul_pkg.sv
// Shared types and helpers for the sequential signed fractional multiplier.
// frac_sat() turns a full-width signed product into a saturated Q1.(n-1) result.
package frac_mul_pkg;

  typedef enum logic [1:0] {IDLE, RUN, WB} mul_state_t;

  localparam int N_DEFAULT = 8;
  localparam int MAX_N     = 32;
  localparam int CNT_W     = $clog2(N_DEFAULT + 1);

  // Counter width for an arbitrary data width w: counts 0..w.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  // p holds a 2w-bit signed product in its low bits. The result is p[2w-2:w-1],
  // clamped when bits 2w-1 and 2w-2 disagree (only -1.0 * -1.0 can cause that).
  function automatic logic [MAX_N-1:0] frac_sat(input logic [2*MAX_N-1:0] p,
                                                input int w);
    logic [2*MAX_N-1:0] one;
    logic [2*MAX_N-1:0] shifted;
    logic [2*MAX_N-1:0] lim;
    logic [1:0]         top2;
    one     = {{(2*MAX_N-1){1'b0}}, 1'b1};
    shifted = p >> (w - 1);
    top2    = 2'(p >> (2 * w - 2));
    lim     = (one << (w - 1)) - one;
    if (top2[1] != top2[0]) shifted = top2[1] ? ~lim : lim;
    return MAX_N'(shifted);
  endfunction

endpackage

// File: rtl/frac_mul_seq.sv
// Sequential signed Q1.(n-1) shift-add multiplier driving the register-file write port.
// Magnitudes are multiplied over n cycles, then the signed product is sliced and saturated.
module frac_mul_seq
  import frac_mul_pkg::*;
#(
  parameter int n = N_DEFAULT
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         start,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic [4:0]   rd_in,
  output logic         busy,
  output logic         w,
  output logic [n-1:0] Wdata,
  output logic [4:0]   wr_addr
);

  localparam int CW = cnt_width(n);
  localparam int PW = 2 * MAX_N;

  mul_state_t     state_q, state_d;
  logic [2*n-1:0] acc_q, acc_d;
  logic [2*n-1:0] mcand_q, mcand_d;
  logic [n-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sign_q, sign_d;
  logic [4:0]     rd_q, rd_d;
  logic           busy_q, busy_d;
  logic           w_q, w_d;
  logic [n-1:0]   wdata_q, wdata_d;
  logic [4:0]     wr_addr_q, wr_addr_d;

  logic [n-1:0]   a_mag, b_mag;
  logic [2*n-1:0] acc_sum, prod;

  always_comb begin
    // NOTE: every variable gets a default first, so no path through the case
    // leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    rd_d      = rd_q;
    busy_d    = busy_q;
    w_d       = w_q;
    wdata_d   = wdata_q;
    wr_addr_d = wr_addr_q;

    a_mag   = a[n-1] ? -a : a;
    b_mag   = b[n-1] ? -b : b;
    acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    prod    = sign_q ? -acc_sum : acc_sum;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          acc_d    = '0;
          mcand_d  = {{n{1'b0}}, a_mag};
          mplier_d = b_mag;
          cnt_d    = '0;
          sign_d   = a[n-1] ^ b[n-1];
          rd_d     = rd_in;
          busy_d   = 1'b1;
        end
      end
      RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        // The last iteration's sum is used directly so the result lands on this edge.
        if (cnt_q == CW'(n - 1)) begin
          state_d   = WB;
          w_d       = 1'b1;
          wdata_d   = n'(frac_sat(PW'(prod), n));
          wr_addr_d = rd_q;
        end
      end
      WB: begin
        state_d = IDLE;
        w_d     = 1'b0;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: datapath registers are reset along with control so an aborted
  // operation leaves nothing stale behind for the next one.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      rd_q      <= '0;
      busy_q    <= 1'b0;
      w_q       <= 1'b0;
      wdata_q   <= '0;
      wr_addr_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      sign_q    <= sign_d;
      rd_q      <= rd_d;
      busy_q    <= busy_d;
      w_q       <= w_d;
      wdata_q   <= wdata_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  assign busy    = busy_q;
  assign w       = w_q;
  assign Wdata   = wdata_q;
  assign wr_addr = wr_addr_q;

endmodule

// File: tb/tb_frac_mul_seq.sv
// Bench for frac_mul_seq: an 8-bit and a 12-bit instance run side by side against
// an arithmetic reference model floor(a*b / 2^(n-1)) with saturation.
module tb_frac_mul_seq;

  logic        clk = 1'b0;
  logic        nReset;
  logic        start;
  logic [7:0]  a8, b8;
  logic [11:0] a12, b12;
  logic [4:0]  rd8, rd12;
  logic        busy8, w8, busy12, w12;
  logic [7:0]  wdata8;
  logic [11:0] wdata12;
  logic [4:0]  wr_addr8, wr_addr12;

  int total = 0;
  int bad   = 0;

  // Results of the most recent run_pair window.
  int          r_wc8, r_wpos8, r_bc8, r_wc12, r_wpos12, r_bc12;
  logic [7:0]  r_wd8;
  logic [11:0] r_wd12;
  logic [4:0]  r_wa8, r_wa12;

  always #5 clk = ~clk;

  frac_mul_seq #(.n(8)) dut8 (
    .clk(clk), .nReset(nReset), .start(start), .a(a8), .b(b8), .rd_in(rd8),
    .busy(busy8), .w(w8), .Wdata(wdata8), .wr_addr(wr_addr8)
  );

  frac_mul_seq #(.n(12)) dut12 (
    .clk(clk), .nReset(nReset), .start(start), .a(a12), .b(b12), .rd_in(rd12),
    .busy(busy12), .w(w12), .Wdata(wdata12), .wr_addr(wr_addr12)
  );

  function automatic longint ref_mul(input longint av, input longint bv, input int wd);
    longint sa, sb, r, maxv, full;
    full = longint'(1) << wd;
    maxv = (longint'(1) << (wd - 1)) - 1;
    sa = (av > maxv) ? av - full : av;
    sb = (bv > maxv) ? bv - full : bv;
    r  = (sa * sb) >>> (wd - 1);
    if (r > maxv) r = maxv;
    return r & (full - 1);
  endfunction

  // Start both instances on one edge, scramble the inputs afterwards, and log
  // 18 cycles of outputs. Cycle 0 is the one right after the accept edge.
  task automatic run_pair(input logic [7:0] ia8, input logic [7:0] ib8, input logic [4:0] ird8,
                          input logic [11:0] ia12, input logic [11:0] ib12,
                          input logic [4:0] ird12);
    @(negedge clk);
    a8 = ia8; b8 = ib8; rd8 = ird8; a12 = ia12; b12 = ib12; rd12 = ird12;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); rd8 = 5'($urandom);
    a12 = 12'($urandom); b12 = 12'($urandom); rd12 = 5'($urandom);
    r_wc8 = 0; r_wpos8 = -1; r_bc8 = 0; r_wc12 = 0; r_wpos12 = -1; r_bc12 = 0;
    for (int i = 0; i < 18; i++) begin
      if (busy8) r_bc8++;
      if (w8) begin
        r_wc8++; r_wd8 = wdata8; r_wa8 = wr_addr8;
        if (r_wpos8 < 0) r_wpos8 = i;
      end
      if (busy12) r_bc12++;
      if (w12) begin
        r_wc12++; r_wd12 = wdata12; r_wa12 = wr_addr12;
        if (r_wpos12 < 0) r_wpos12 = i;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #2;
    total++;
    if ({busy8, w8, wdata8, wr_addr8} !== 15'h0) begin
      bad++;
      $display("FAIL reset8 got busy=%b w=%b Wdata=%h wr_addr=%0d want all 0",
               busy8, w8, wdata8, wr_addr8);
    end
    total++;
    if ({busy12, w12, wdata12, wr_addr12} !== 19'h0) begin
      bad++;
      $display("FAIL reset12 got busy=%b w=%b Wdata=%h wr_addr=%0d want all 0",
               busy12, w12, wdata12, wr_addr12);
    end
    @(negedge clk);
    nReset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [7:0] ta [6] = '{8'h40, 8'hC0, 8'hFF, 8'h00, 8'h80, 8'h80};
    logic [7:0] tb [6] = '{8'h40, 8'h40, 8'h01, 8'h7F, 8'h80, 8'h7F};
    logic [7:0] te [6] = '{8'h20, 8'hE0, 8'hFF, 8'h00, 8'h7F, 8'h81};
    for (int k = 0; k < 6; k++) begin
      run_pair(ta[k], tb[k], 5'(k + 5), 12'h400, 12'h400, 5'd0);
      total++;
      if (r_wc8 != 1 || r_wd8 !== te[k] || r_wa8 !== 5'(k + 5)) begin
        bad++;
        $display("FAIL directed%0d got pulses=%0d Wdata=%h wr_addr=%0d want 1 %h %0d",
                 k, r_wc8, r_wd8, r_wa8, 1, te[k], k + 5);
      end
      total++;
      if (r_wpos8 != 8 || r_bc8 != 9) begin
        bad++;
        $display("FAIL latency8_%0d got w_cycle=%0d busy_cycles=%0d want 8 9",
                 k, r_wpos8, r_bc8);
      end
    end
    total++;
    if (r_wc12 != 1 || r_wd12 !== 12'h200 || r_wa12 !== 5'd0 || r_wpos12 != 12 || r_bc12 != 13) begin
      bad++;
      $display("FAIL rd0_n12 got pulses=%0d Wdata=%h wr_addr=%0d w_cycle=%0d busy=%0d want 1 200 0 12 13",
               r_wc12, r_wd12, r_wa12, r_wpos12, r_bc12);
    end
  endtask

  task automatic test_ignore_start;
    int wc8 = 0;
    int wc12 = 0;
    logic [7:0]  wd8 = '0;
    logic [11:0] wd12 = '0;
    logic [4:0]  wa8 = '0;
    logic [4:0]  wa12 = '0;
    @(negedge clk);
    a8 = 8'h40; b8 = 8'h40; rd8 = 5'd5; a12 = 12'h400; b12 = 12'h400; rd12 = 5'd7;
    start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      if (w8) begin wc8++; wd8 = wdata8; wa8 = wr_addr8; end
      if (w12) begin wc12++; wd12 = wdata12; wa12 = wr_addr12; end
      if (i == 3 || i == 8) begin
        start = 1'b1;
        a8 = 8'h7F; b8 = 8'h7F; rd8 = 5'd9; a12 = 12'h7FF; b12 = 12'h7FF; rd12 = 5'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    total++;
    if (wc8 != 1 || wd8 !== 8'h20 || wa8 !== 5'd5) begin
      bad++;
      $display("FAIL ignore8 got pulses=%0d Wdata=%h wr_addr=%0d want 1 20 5", wc8, wd8, wa8);
    end
    total++;
    if (wc12 != 1 || wd12 !== 12'h200 || wa12 !== 5'd7) begin
      bad++;
      $display("FAIL ignore12 got pulses=%0d Wdata=%h wr_addr=%0d want 1 200 7", wc12, wd12, wa12);
    end
  endtask

  task automatic test_held_start;
    int q8[$];
    int q12[$];
    @(negedge clk);
    a8 = 8'h40; b8 = 8'hC0; rd8 = 5'd3; a12 = 12'h400; b12 = 12'h400; rd12 = 5'd3;
    start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 60; i++) begin
      if (w8) q8.push_back(i);
      if (w12) q12.push_back(i);
      @(negedge clk);
    end
    start = 1'b0;
    total++;
    if (q8.size() != 6) begin
      bad++;
      $display("FAIL held8_count got %0d want 6", q8.size());
    end
    foreach (q8[j]) begin
      total++;
      if (q8[j] != 8 + 10 * j) begin
        bad++;
        $display("FAIL held8_pos%0d got %0d want %0d", j, q8[j], 8 + 10 * j);
      end
    end
    total++;
    if (q12.size() != 4) begin
      bad++;
      $display("FAIL held12_count got %0d want 4", q12.size());
    end
    foreach (q12[j]) begin
      total++;
      if (q12[j] != 12 + 14 * j) begin
        bad++;
        $display("FAIL held12_pos%0d got %0d want %0d", j, q12[j], 12 + 14 * j);
      end
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int wc = 0;
    @(negedge clk);
    a8 = 8'h40; b8 = 8'h40; rd8 = 5'd5; a12 = 12'h400; b12 = 12'h400; rd12 = 5'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    nReset = 1'b0;
    #1;
    total++;
    if ({busy8, w8, wdata8, wr_addr8, busy12, w12, wdata12, wr_addr12} !== 34'h0) begin
      bad++;
      $display("FAIL abort got busy8=%b w8=%b Wdata8=%h busy12=%b w12=%b Wdata12=%h want all 0",
               busy8, w8, wdata8, busy12, w12, wdata12);
    end
    @(negedge clk);
    @(negedge clk);
    nReset = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (w8 || w12 || busy8 || busy12) wc++;
      @(negedge clk);
    end
    total++;
    if (wc != 0) begin
      bad++;
      $display("FAIL after_abort got %0d active cycles want 0", wc);
    end
    run_pair(8'hC0, 8'h40, 5'd12, 12'hC00, 12'h400, 5'd13);
    total++;
    if (r_wc8 != 1 || r_wd8 !== 8'hE0 || r_wa8 !== 5'd12) begin
      bad++;
      $display("FAIL post_abort8 got pulses=%0d Wdata=%h wr_addr=%0d want 1 e0 12", r_wc8, r_wd8, r_wa8);
    end
    total++;
    if (r_wc12 != 1 || r_wd12 !== 12'hE00 || r_wa12 !== 5'd13) begin
      bad++;
      $display("FAIL post_abort12 got pulses=%0d Wdata=%h wr_addr=%0d want 1 e00 13", r_wc12, r_wd12, r_wa12);
    end
  endtask

  task automatic test_random;
    logic [7:0]  ra8, rb8, e8;
    logic [11:0] ra12, rb12, e12;
    logic [4:0]  rr8, rr12;
    for (int k = 0; k < 1000; k++) begin
      ra8 = 8'($urandom); rb8 = 8'($urandom); rr8 = 5'($urandom);
      ra12 = 12'($urandom); rb12 = 12'($urandom); rr12 = 5'($urandom);
      if ($urandom_range(0, 15) == 0) begin ra8 = 8'h80; rb8 = 8'h80; end
      if ($urandom_range(0, 15) == 0) begin ra12 = 12'h800; rb12 = 12'h800; end
      e8  = 8'(ref_mul(longint'(ra8), longint'(rb8), 8));
      e12 = 12'(ref_mul(longint'(ra12), longint'(rb12), 12));
      run_pair(ra8, rb8, rr8, ra12, rb12, rr12);
      total++;
      if (r_wc8 != 1 || r_wpos8 != 8 || r_wd8 !== e8 || r_wa8 !== rr8) begin
        bad++;
        $display("FAIL rand8 a=%h b=%h got pulses=%0d cyc=%0d Wdata=%h wr_addr=%0d want 1 8 %h %0d",
                 ra8, rb8, r_wc8, r_wpos8, r_wd8, r_wa8, e8, rr8);
      end
      total++;
      if (r_wc12 != 1 || r_wpos12 != 12 || r_wd12 !== e12 || r_wa12 !== rr12) begin
        bad++;
        $display("FAIL rand12 a=%h b=%h got pulses=%0d cyc=%0d Wdata=%h wr_addr=%0d want 1 12 %h %0d",
                 ra12, rb12, r_wc12, r_wpos12, r_wd12, r_wa12, e12, rr12);
      end
    end
  endtask

  initial begin
    nReset = 1'b0;
    start  = 1'b0;
    a8 = '0; b8 = '0; rd8 = '0; a12 = '0; b12 = '0; rd12 = '0;
    test_reset();
    test_directed();
    test_ignore_start();
    test_held_start();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
